ps2_host_ctrl: RTL and testbench
================================

# ps2_host_ctrl

Host-to-device command controller for the PS/2 port. Accepts one command byte at a time, for example 0xED followed by an LED mask, or 0xFF for reset. It runs the PS/2 host-transmit sequence: inhibit, request-to-send, bit shifting on device clock edges, and the ACK bit. It then waits for the device's 0xFA/0xFE response byte, arriving through `ps2_receiver`, and retries on resend. The block sits beside `ps2_receiver`/`ps2_parser` inside `ps2_unit` and owns the open-drain drive of `ps2_clk`/`ps2_data`.

## Interface
Parameters:
- `INHIBIT_CYCLES`, 5000 — clock-low inhibit length in `clk` cycles (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 1000000 — per-phase watchdog (20 ms at 50 MHz).
- `MAX_RETRIES`, 3 — resend attempts after the first try.

Ports:
- `clk`  in  1  system clock; the block uses this single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ps2_clk_in`  in  1  raw PS/2 clock pin value, unsynchronized.
- `ps2_data_in`  in  1  raw PS/2 data pin value, unsynchronized.
- `ps2_clk_oe`  out  1  1 = pull `ps2_clk` low; 0 = release (z).
- `ps2_data_oe`  out  1  1 = pull `ps2_data` low; 0 = release (z).
- `cmd_valid`  in  1  command byte offered.
- `cmd_byte`  in  8  command byte.
- `cmd_ready`  out  1  high only in IDLE.
- `rx_packet_done`  in  1  pulse from `ps2_receiver`.
- `rx_byte`  in  8  `ps2_data_byte` from `ps2_receiver`.
- `rx_hold`  out  1  holds the receiver's bit counter cleared while the host transmits.
- `busy`  out  1  state != IDLE.
- `done`  out  1  1-cycle pulse: device answered 0xFA.
- `error`  out  1  1-cycle pulse: timeout, retries exhausted, or unexpected response.

## Operation
- `ps2_clk_in`/`ps2_data_in` pass through a 2-flop synchronizer. A falling edge `fall` is flagged when the synchronized clock goes 1→0.
- States: IDLE, INHIBIT, RTS, SEND, ACK, WAIT_RESP.
- **IDLE:** all outputs released; `cmd_ready`=1.
  - On `cmd_valid` & `cmd_ready`: latch `cmd_byte`, clear retry count, go to INHIBIT.
  - `cmd_valid` without `cmd_ready` is ignored and not queued.
- **INHIBIT:** `ps2_clk_oe`=1 and `rx_hold`=1 for INHIBIT_CYCLES cycles.
  - `ps2_data_oe` rises on the final inhibit cycle.
  - Then go to RTS.
- **RTS:** `ps2_clk_oe`=0 and `ps2_data_oe`=1; this is the start bit.
  - Bit counter n=0.
  - On first `fall`, go to SEND.
- **SEND:** each `fall` advances n. The value driven on the line for each n:
  - n=1..8: `cmd_byte[n-1]`, with `ps2_data_oe` = ~bit.
  - n=9: odd parity = ~^`cmd_byte`.
  - n=10: stop bit, line released.
  - After the stop bit is driven, go to ACK.
- **ACK:** on the next `fall`, sample synchronized data.
  - 0 → go to WAIT_RESP and drop `rx_hold`.
  - 1 → treated as a resend request.
- **WAIT_RESP:** on `rx_packet_done`:
  - 0xFA → `done`, go to IDLE.
  - 0xFE → resend request.
  - Any other byte → `error`, go to IDLE.
- **Resend request:**
  - If retries < MAX_RETRIES: increment retries and go to INHIBIT with the same byte.
  - Otherwise: `error`, go to IDLE.
- **Watchdog:** the timeout counter clears on every state entry and on every `fall`. Reaching TIMEOUT_CYCLES in RTS, SEND, ACK or WAIT_RESP → `error`, release both lines, go to IDLE.
- `rx_hold` is high from INHIBIT entry through ACK. It is also high on any abort, for the cycle that IDLE is re-entered.

## Timing
- **Reset values:** all outputs 0, state IDLE. `cmd_ready` becomes 1 on the first cycle after `rst` deasserts.
- **Reset mid-operation:** both OEs drop asynchronously, releasing the bus, and no `done`/`error` is issued.
- **Accept to clock-low:** `ps2_clk_oe` is high 1 cycle after the accepting edge.
- **Edge-to-drive latency:** data changes 3 `clk` cycles after the pin falls (2 sync + 1 register). This is well inside the device's half-period.
- **`done`/`error` timing:** asserted on the cycle after the causing event, and never both at once. `cmd_ready` is 1 in that same cycle.
- **Simultaneous events:** `rx_packet_done` seen outside WAIT_RESP is ignored. A watchdog expiry and a `fall` in the same cycle: the `fall` wins.
- **Counter widths:** `$clog2(TIMEOUT_CYCLES+1)`; the retry counter is `$clog2(MAX_RETRIES+1)`.

## Structure
- Add to `ps2.vh`:
  - `` `SCAN_ACK `` (8'hFA) and `` `SCAN_RESEND `` (8'hFE), next to `` `SCAN_KEY_UP ``.
  - `` `PS2_CMD_SET_LEDS `` (8'hED) and `` `PS2_CMD_RESET `` (8'hFF).
  - The state encodings.
- Sub-module `ps2_sync_edge`: 2-flop synchronizer plus falling-edge detect for clock and data. `ps2_receiver` will reuse it later.
- Registers use `ff_ar`; counters use `counter`.

## Test plan
All scenarios use INHIBIT_CYCLES=8 and TIMEOUT_CYCLES=200. The device BFM clocks at 40-cycle period.
- Send 0xED; BFM ACKs and replies 0xFA → bits 1,0,1,1,0,1,1,1 then parity 1; `done` pulse, `error` never asserted.
- Send 0xFF; BFM replies 0xFE twice then 0xFA → exactly 3 INHIBIT phases, then `done`.
- Send 0x55; BFM always replies 0xFE → 4 attempts (1 + MAX_RETRIES), then `error`.
- Send 0xF4; BFM never clocks → `error` 200 cycles after RTS entry, both OEs 0.
- Send 0xED; BFM leaves data high at the ACK bit → retry; 0xFA on the second attempt → `done`.
- Assert `rst` during SEND bit 5 → OEs 0 the same cycle, IDLE after release, a new command is accepted normally.

Source files
------------

// File: rtl/ps2_host_ctrl_pkg.sv
// Shared PS/2 constants, controller state encoding and the host-to-device frame bit helper.
package ps2_host_ctrl_pkg;

    localparam logic [7:0] SCAN_KEY_UP      = 8'hF0;
    localparam logic [7:0] SCAN_ACK         = 8'hFA;
    localparam logic [7:0] SCAN_RESEND      = 8'hFE;
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_RESP = 3'd5
    } state_t;

    localparam logic [3:0] BIT_PARITY = 4'd9;

    // Line level for frame position n: 0 start, 1..8 data LSB first, 9 odd parity, else released.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] n);
        logic v;
        v = 1'b1;
        if (n == 4'd0) begin
            v = 1'b0;
        end else if (n <= 4'd8) begin
            v = b[3'(n - 4'd1)];
        end else if (n == BIT_PARITY) begin
            v = ~^b;
        end
        return v;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the PS/2 clock and data pins with a clock falling-edge flag.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_fall,
    output logic data_s
);

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;

    // Reset to the idle-high bus level so leaving reset never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= clk_in;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= data_in;
            data_sync_q <= data_meta_q;
        end
    end

    assign clk_fall = clk_prev_q & ~clk_sync_q;
    assign data_s   = data_sync_q;

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host-to-device command sender: inhibit, request-to-send, bit shifting, ACK and
// device response handling with bounded resend retries and a per-phase watchdog.
module ps2_host_ctrl
    import ps2_host_ctrl_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_byte,
    output logic       cmd_ready,
    input  logic       rx_packet_done,
    input  logic [7:0] rx_byte,
    output logic       rx_hold,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] dbg_state
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int TW      = $clog2(CNT_MAX + 1);
    localparam int RW      = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [TW-1:0] INH_LAST  = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    logic fall, data_s;

    ps2_sync_edge u_sync (
        .clk      (clk),
        .rst      (rst),
        .clk_in   (ps2_clk_in),
        .data_in  (ps2_data_in),
        .clk_fall (fall),
        .data_s   (data_s)
    );

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [3:0]    n_q, n_d;
    logic [7:0]    byte_q, byte_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic          ready_q, ready_d, busy_q, busy_d, hold_q, hold_d;
    logic          done_q, done_d, error_q, error_d;
    logic          resend, timed_out;

    // A command is taken when cmd_valid and cmd_ready are both high on a clk edge;
    // cmd_ready is high only in IDLE and an offer while busy is dropped, not queued.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q + TW'(1);
        n_d       = n_q;
        byte_d    = byte_q;
        retry_d   = retry_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        resend    = 1'b0;
        timed_out = (tmr_q == TO_LAST) && !fall;

        case (state_q)
            ST_IDLE: begin
                tmr_d = '0;
                if (cmd_valid && ready_q) begin
                    byte_d  = cmd_byte;
                    retry_d = '0;
                    state_d = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (tmr_q == INH_LAST) begin
                    state_d = ST_RTS;
                    n_d     = 4'd0;
                end
            end
            ST_RTS: begin
                if (fall) begin
                    state_d = ST_SEND;
                    n_d     = 4'd1;
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (fall) begin
                    n_d = n_q + 4'd1;
                    if (n_q == BIT_PARITY) state_d = ST_ACK;
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (fall) begin
                    if (!data_s) state_d = ST_WAIT_RESP;
                    else         resend  = 1'b1;
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_RESP: begin
                if (rx_packet_done) begin
                    if (rx_byte == SCAN_ACK) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (rx_byte == SCAN_RESEND) begin
                        resend = 1'b1;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (resend) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + RW'(1);
                state_d = ST_INHIBIT;
            end else begin
                error_d = 1'b1;
                state_d = ST_IDLE;
            end
        end

        if ((state_d != state_q) || (fall && state_q != ST_IDLE && state_q != ST_INHIBIT)) begin
            tmr_d = '0;
        end

        // Pin drives are decoded from next state so they leave a flop glitch-free.
        clk_oe_d = (state_d == ST_INHIBIT);
        case (state_d)
            ST_INHIBIT: data_oe_d = (tmr_d == INH_LAST);
            ST_RTS:     data_oe_d = 1'b1;
            ST_SEND:    data_oe_d = ~frame_bit(byte_d, n_d);
            default:    data_oe_d = 1'b0;
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        hold_d  = (state_d inside {ST_INHIBIT, ST_RTS, ST_SEND, ST_ACK}) || error_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tmr_q     <= '0;
            n_q       <= 4'd0;
            byte_q    <= 8'h00;
            retry_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            hold_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            n_q       <= n_d;
            byte_q    <= byte_d;
            retry_q   <= retry_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign cmd_ready   = ready_q;
    assign busy        = busy_q;
    assign rx_hold     = hold_q;
    assign done        = done_q;
    assign error       = error_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Directed bench for ps2_host_ctrl: a PS/2 device model clocks frames out of the host,
// answers ACK/resend, and response bytes are injected on the receiver-side inputs.
module tb_ps2_host_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0, S_INHIBIT = 3'd1, S_RTS = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3, S_WAIT = 3'd5;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_byte;
    logic       rx_packet_done;
    logic [7:0] rx_byte;
    logic       rx_hold, busy, done, error;
    logic [2:0] dbg_state;
    logic       bfm_clk_low, bfm_data_low;
    logic       line_clk, line_data;

    assign line_clk  = ~(ps2_clk_oe | bfm_clk_low);
    assign line_data = ~(ps2_data_oe | bfm_data_low);

    ps2_host_ctrl #(
        .INHIBIT_CYCLES (8),
        .TIMEOUT_CYCLES (200),
        .MAX_RETRIES    (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ps2_clk_in     (line_clk),
        .ps2_data_in    (line_data),
        .ps2_clk_oe     (ps2_clk_oe),
        .ps2_data_oe    (ps2_data_oe),
        .cmd_valid      (cmd_valid),
        .cmd_byte       (cmd_byte),
        .cmd_ready      (cmd_ready),
        .rx_packet_done (rx_packet_done),
        .rx_byte        (rx_byte),
        .rx_hold        (rx_hold),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse and inhibit-phase counters, sampled mid-cycle.
    int   inhibit_cnt, done_cnt, err_cnt, both_cnt;
    logic mon_clr = 1'b1;
    logic clk_oe_prev = 1'b0;
    always @(negedge clk) begin
        if (mon_clr) begin
            inhibit_cnt = 0;
            done_cnt    = 0;
            err_cnt     = 0;
            both_cnt    = 0;
        end else begin
            if (ps2_clk_oe && !clk_oe_prev) inhibit_cnt++;
            if (done) done_cnt++;
            if (error) err_cnt++;
            if (done && error) both_cnt++;
        end
        clk_oe_prev = ps2_clk_oe;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick(1);
        mon_clr = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        cmd_byte  = b;
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic send_resp(input logic [7:0] b);
        rx_byte        = b;
        rx_packet_done = 1'b1;
        tick(1);
        rx_packet_done = 1'b0;
    endtask

    logic lat2, lat3;

    // Device side: waits for RTS, clocks 10 bits at a 40-cycle period sampling just before
    // each rising edge, then gives the ACK clock with data low when ack_ok is set.
    // abort_k > 0 stops with the clock held low a few cycles after that falling edge.
    task automatic dev_frame(input logic ack_ok, input int abort_k,
                             output logic [10:0] frame, output logic ok);
        int w;
        ok    = 1'b1;
        frame = '0;
        w     = 0;
        while (!(ps2_data_oe && !ps2_clk_oe) && w < 2000) begin
            tick(1);
            w++;
        end
        if (w >= 2000) begin
            ok = 1'b0;
            return;
        end
        tick(10);
        frame[0] = line_data;
        for (int k = 1; k <= 10; k++) begin
            bfm_clk_low = 1'b1;
            if (k == abort_k) begin
                tick(4);
                ok = 1'b0;
                return;
            end
            tick(2);
            if (k == 1) lat2 = ps2_data_oe;
            tick(1);
            if (k == 1) lat3 = ps2_data_oe;
            tick(17);
            frame[k]    = line_data;
            bfm_clk_low = 1'b0;
            tick(20);
        end
        bfm_data_low = ack_ok;
        tick(5);
        bfm_clk_low = 1'b1;
        tick(20);
        bfm_clk_low = 1'b0;
        tick(5);
        bfm_data_low = 1'b0;
        tick(15);
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    logic [10:0] frame;
    logic        ok;
    int          good_frames;
    int          w, c;

    initial begin
        rst            = 1'b1;
        cmd_valid      = 1'b0;
        cmd_byte       = 8'h00;
        rx_packet_done = 1'b0;
        rx_byte        = 8'h00;
        bfm_clk_low    = 1'b0;
        bfm_data_low   = 1'b0;
        lat2           = 1'b0;
        lat3           = 1'b0;
        tick(3);
        check_eq("reset_outputs", {ps2_clk_oe, ps2_data_oe, cmd_ready, busy, done, error, rx_hold}, 0);
        rst = 1'b0;
        tick(1);
        check_eq("ready_after_rst", {cmd_ready, busy, dbg_state}, {1'b1, 1'b0, S_IDLE});
        clear_mon();

        // 0xED, clean ACK and 0xFA; frame {stop,parity,data,start} = {1,1,ED,0} = 0x7DA
        send_cmd(8'hED);
        check_eq("accept", {ps2_clk_oe, busy, cmd_ready, rx_hold}, 4'b1101);
        cmd_byte  = 8'h00;
        cmd_valid = 1'b1;
        tick(6);
        check_eq("inhibit_data_early", ps2_data_oe, 0);
        cmd_valid = 1'b0;
        tick(1);
        check_eq("inhibit_last", {ps2_clk_oe, ps2_data_oe}, 2'b11);
        tick(1);
        check_eq("rts_entry", {ps2_clk_oe, ps2_data_oe, dbg_state}, {2'b01, S_RTS});
        dev_frame(1'b1, 0, frame, ok);
        check_eq("s1_frame_ok", ok, 1);
        check_eq("s1_frame", frame, 11'h7DA);
        check_eq("edge_latency", {lat2, lat3}, 2'b10);
        check_eq("s1_wait_resp", {dbg_state, rx_hold}, {S_WAIT, 1'b0});
        send_resp(8'hFA);
        check_eq("s1_done", {done, error, cmd_ready}, 3'b101);
        tick(3);
        check_eq("s1_counts", {8'(done_cnt), 8'(err_cnt), 8'(inhibit_cnt), 1'b0, busy}, {8'd1, 8'd0, 8'd1, 2'b00});

        // 0xFF, resend twice then 0xFA; frame {1,1,FF,0} = 0x7FE
        clear_mon();
        send_cmd(8'hFF);
        good_frames = 0;
        for (int i = 0; i < 3; i++) begin
            dev_frame(1'b1, 0, frame, ok);
            if (ok && frame == 11'h7FE) good_frames++;
            send_resp((i < 2) ? 8'hFE : 8'hFA);
        end
        check_eq("s2_done", {done, error, cmd_ready}, 3'b101);
        check_eq("s2_frames", good_frames, 3);
        tick(3);
        check_eq("s2_counts", {8'(inhibit_cnt), 8'(done_cnt), 8'(err_cnt)}, {8'd3, 8'd1, 8'd0});

        // 0x55, resend forever -> 4 attempts then error; frame {1,1,55,0} = 0x6AA
        clear_mon();
        send_cmd(8'h55);
        good_frames = 0;
        for (int i = 0; i < 4; i++) begin
            dev_frame(1'b1, 0, frame, ok);
            if (ok && frame == 11'h6AA) good_frames++;
            send_resp(8'hFE);
        end
        check_eq("s3_error", {done, error, cmd_ready, rx_hold}, 4'b0111);
        check_eq("s3_frames", good_frames, 4);
        tick(3);
        check_eq("s3_counts", {8'(inhibit_cnt), 8'(done_cnt), 8'(err_cnt)}, {8'd4, 8'd0, 8'd1});

        // 0xF4, device never clocks -> error 200 cycles after RTS entry
        clear_mon();
        send_cmd(8'hF4);
        w = 0;
        while (dbg_state != S_RTS && w < 50) begin
            tick(1);
            w++;
        end
        check_eq("s4_rts_reached", dbg_state, S_RTS);
        c = 0;
        while (!error && c < 400) begin
            tick(1);
            c++;
        end
        check_eq("s4_timeout_cycles", c, 200);
        check_eq("s4_abort_outputs", {ps2_clk_oe, ps2_data_oe, error, done, rx_hold}, 5'b00101);
        tick(3);
        check_eq("s4_counts", {8'(done_cnt), 8'(err_cnt)}, {8'd0, 8'd1});

        // 0xED, data left high at the ACK clock -> one retry, then 0xFA
        clear_mon();
        send_cmd(8'hED);
        dev_frame(1'b0, 0, frame, ok);
        check_eq("s5_frame1", frame, 11'h7DA);
        dev_frame(1'b1, 0, frame, ok);
        check_eq("s5_frame2", frame, 11'h7DA);
        send_resp(8'hFA);
        check_eq("s5_done", {done, error}, 2'b10);
        tick(3);
        check_eq("s5_counts", {8'(inhibit_cnt), 8'(done_cnt), 8'(err_cnt)}, {8'd2, 8'd1, 8'd0});

        // 0x07, reset while bit 5 (cmd[4]=0, line pulled) is driven
        clear_mon();
        send_cmd(8'h07);
        dev_frame(1'b1, 5, frame, ok);
        check_eq("s6_bit5_driven", {dbg_state, ps2_data_oe}, {S_SEND, 1'b1});
        #2;
        rst = 1'b1;
        #1;
        check_eq("s6_async_release", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        bfm_clk_low = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check_eq("s6_idle", {cmd_ready, busy, dbg_state}, {2'b10, S_IDLE});
        check_eq("s6_no_pulses", {8'(done_cnt), 8'(err_cnt)}, 16'd0);
        // frame {1,0,07,0} = 0x40E (three ones -> parity 0)
        send_cmd(8'h07);
        dev_frame(1'b1, 0, frame, ok);
        check_eq("s6_frame", frame, 11'h40E);
        send_resp(8'hFA);
        check_eq("s6_done", {done, error, cmd_ready}, 3'b101);
        tick(3);
        check_eq("never_both", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
